// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - shared types and a width-generic reference add/sub
// Used by the pipelined adder and available to scoreboards.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int MAX_WIDTH = 64;

  // Returns {overflow, carry, sum}; only the low 'width' bits of sum are meaningful.
  function automatic logic [MAX_WIDTH+1:0] ref_add(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic                 cin,
    input op_e                  op,
    input int                   width
  );
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] b_eff;
    logic [MAX_WIDTH-1:0] sum;
    logic [MAX_WIDTH:0]   full;
    logic                 c0;
    logic                 carry;
    logic                 overflow;
    mask  = (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
    b_eff = (op == OP_SUB) ? ~b : b;
    c0    = (op == OP_SUB) ? ~cin : cin;
    full  = {1'b0, a & mask} + {1'b0, b_eff & mask} + {{MAX_WIDTH{1'b0}}, c0};
    sum   = full[MAX_WIDTH-1:0] & mask;
    carry = full[7'(width)];
    overflow = carry ^ (a[6'(width - 1)] ^ b_eff[6'(width - 1)] ^ sum[6'(width - 1)]);
    return {overflow, carry, sum};
  endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// rtl/pipelined_adder_slice.sv - one SEG-bit carry slice with its pipeline register
// Slice K sums bits [K*SEG +: SEG] and forwards the operands still to be summed.
module adder_slice #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic [WIDTH-1:0] up_sum,
  input  logic             up_carry,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_a,
  output logic [WIDTH-1:0] dn_b,
  output logic [WIDTH-1:0] dn_sum,
  output logic             dn_carry,
  output logic             dn_overflow
);

  localparam int LO = K * SEG;

  logic [SEG:0]     seg_full;
  logic [WIDTH-1:0] sum_next;
  logic             msb_cin;

  assign seg_full = {1'b0, up_a[LO +: SEG]} + {1'b0, up_b[LO +: SEG]} + {{SEG{1'b0}}, up_carry};
  // Carry into the slice's top bit, recovered from the sum bit; needed for signed overflow.
  assign msb_cin  = up_a[LO+SEG-1] ^ up_b[LO+SEG-1] ^ seg_full[SEG-1];

  always_comb begin
    sum_next            = up_sum;
    sum_next[LO +: SEG] = seg_full[SEG-1:0];
  end

  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid    <= 1'b0;
      dn_a        <= '0;
      dn_b        <= '0;
      dn_sum      <= '0;
      dn_carry    <= 1'b0;
      dn_overflow <= 1'b0;
    end else begin
      if (up_ready) begin
        dn_valid <= up_valid;
      end
      if (up_valid && up_ready) begin
        dn_a        <= up_a;
        dn_b        <= up_b;
        dn_sum      <= sum_next;
        dn_carry    <= seg_full[SEG];
        dn_overflow <= seg_full[SEG] ^ msb_cin;
      end
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - WIDTH-bit add/subtract split over STAGES registered carry slices
// Valid/ready on both sides; in_ready is a purely combinational backward chain.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int SEG = WIDTH / ((STAGES < 1) ? 1 : STAGES);

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % ((STAGES < 1) ? 1 : STAGES)) != 0) begin : g_bad_params
    $fatal(1, "pipelined_adder: WIDTH must be >=1 and divisible by STAGES >= 1");
  end

  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign op    = op_e'(sub);
  // Subtraction as a + ~b + ~cin, so carry=1 means no borrow.
  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign c0    = (op == OP_SUB) ? ~cin : cin;

  logic             v_p [STAGES+1];
  logic             r_p [STAGES+1];
  logic [WIDTH-1:0] a_p [STAGES+1];
  logic [WIDTH-1:0] b_p [STAGES+1];
  logic [WIDTH-1:0] s_p [STAGES+1];
  logic             c_p [STAGES+1];
  logic             o_p [1:STAGES];

  assign v_p[0]      = in_valid;
  assign a_p[0]      = a;
  assign b_p[0]      = b_eff;
  assign s_p[0]      = '0;
  assign c_p[0]      = c0;
  assign r_p[STAGES] = out_ready;
  assign in_ready    = r_p[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_slice #(
      .WIDTH (WIDTH),
      .SEG   (SEG),
      .K     (k)
    ) u_slice (
      .clk         (clk),
      .rst_n       (rst_n),
      .up_valid    (v_p[k]),
      .up_ready    (r_p[k]),
      .up_a        (a_p[k]),
      .up_b        (b_p[k]),
      .up_sum      (s_p[k]),
      .up_carry    (c_p[k]),
      .dn_valid    (v_p[k+1]),
      .dn_ready    (r_p[k+1]),
      .dn_a        (a_p[k+1]),
      .dn_b        (b_p[k+1]),
      .dn_sum      (s_p[k+1]),
      .dn_carry    (c_p[k+1]),
      .dn_overflow (o_p[k+1])
    );
  end

  // Only the last slice's carry/overflow describe the full-width result.
  assign out_valid = v_p[STAGES];
  assign sum       = s_p[STAGES];
  assign carry     = c_p[STAGES];
  assign overflow  = o_p[STAGES];

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - scoreboard bench: directed 8x2 checks plus random runs over 9 configs
module tb_pipelined_adder;

  localparam int NV = 112;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_bad  = 0;
  int n_done = 0;

  logic       rst_n, rr_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, sum;
  logic       cin, sub, carry, overflow;
  logic [9:0] mq [$];
  logic [9:0] m_exp;

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input logic sv, input logic [9:0] ev);
    int t;
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1; t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++; n_bad++;
      $display("FAIL send_timeout: in_ready held low for %0d cycles", t);
    end else begin
      mq.push_back(ev);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a = 'x; b = 'x; cin = 'x; sub = 'x;
  endtask

  // Main-DUT monitor: pops an expectation on every delivered result.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (mq.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL main_unexpected: result %0h delivered, none expected", {overflow, carry, sum});
      end else begin
        m_exp = mq.pop_front();
        check("main_result", 64'({overflow, carry, sum}), 64'(m_exp));
      end
    end
  end

  for (genvar ci = 0; ci < 9; ci++) begin : g_cfg
    localparam int W = 8 << (ci / 3);
    localparam int S = 1 << (ci % 3);

    logic         iv, ir, ov, orr, cn, sb, cy, of, took;
    logic [W-1:0] ra, rb, rs;
    logic [W+1:0] q [$];
    int           acc, del;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) u_rnd (
      .clk       (clk),
      .rst_n     (rr_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (ra),
      .b         (rb),
      .cin       (cn),
      .sub       (sb),
      .out_valid (ov),
      .out_ready (orr),
      .sum       (rs),
      .carry     (cy),
      .overflow  (of)
    );

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic s);
      longint full, half, ux, uy, sx, sy, r, sr;
      logic   cy_m, ov_m;
      full = longint'(1) << W;
      half = full >>> 1;
      ux = longint'(x);
      uy = longint'(y);
      sx = (ux >= half) ? ux - full : ux;
      sy = (uy >= half) ? uy - full : uy;
      if (s) begin
        r = ux - uy - longint'(c);  cy_m = (r >= 0);
        sr = sx - sy - longint'(c);
      end else begin
        r = ux + uy + longint'(c);  cy_m = (r >= full);
        sr = sx + sy + longint'(c);
      end
      ov_m = (sr >= half) || (sr < -half);
      return {ov_m, cy_m, W'(r)};
    endfunction

    initial begin
      int t;
      iv = 1'b0; orr = 1'b0; ra = '0; rb = '0; cn = 1'b0; sb = 1'b0;
      acc = 0; del = 0; took = 1'b0;
      wait (rr_n === 1'b1);
      while (acc < NV) begin
        @(posedge clk); #1;
        if (!iv || took) begin
          iv = ($urandom_range(3) != 0);
          ra = W'($urandom());
          rb = W'($urandom());
          cn = 1'($urandom());
          sb = 1'($urandom());
        end
        orr = ($urandom_range(2) != 0);
        @(negedge clk);
        took = iv && ir;
        if (took) begin
          q.push_back(model(ra, rb, cn, sb));
          acc++;
        end
      end
      @(posedge clk); #1;
      iv = 1'b0; orr = 1'b1;
      t = 0;
      while (del < acc && t < 500) begin
        @(posedge clk);
        t++;
      end
      check($sformatf("cfg%0d_w%0d_s%0d_count", ci, W, S), 64'(del), 64'(acc));
      n_done++;
    end

    always @(negedge clk) begin
      if (ov && orr) begin
        if (q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL cfg%0d_unexpected: result %0h delivered, none expected", ci, {of, cy, rs});
        end else begin
          check($sformatf("cfg%0d_w%0d_s%0d_result", ci, W, S), 64'({of, cy, rs}), 64'(q.pop_front()));
          del++;
        end
      end
    end
  end

  initial begin
    int idx, t;
    rst_n = 1'b0; rr_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_sum", 64'(sum), 64'(0));
    check("reset_carry", 64'(carry), 64'(0));
    check("reset_overflow", 64'(overflow), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; rr_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'(1));

    @(posedge clk); #1;
    send(8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00});
    @(negedge clk);
    check("latency_early", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("latency_exact", 64'(out_valid), 64'(1));
    @(posedge clk); #1;
    send(8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80});
    send(8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFE});
    send(8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F});
    repeat (4) @(posedge clk);
    #1;
    check("directed_drained", 64'(mq.size()), 64'(0));

    // Backpressure: fill with out_ready low, then release.
    out_ready = 1'b0; idx = 0;
    a = 8'd1; b = 8'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (in_ready) begin
        mq.push_back({2'b00, 8'(2 * (idx + 1))});
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 4) begin a = 8'(idx + 1); b = 8'(idx + 1); end
      else in_valid = 1'b0;
    end
    check("bp_accepts_when_full", 64'(idx), 64'(2));
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready_low", 64'(in_ready), 64'(0));
      check("bp_sum_stable", 64'(sum), 64'(8'h02));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_one_per_cycle", 64'(out_valid), 64'(1));
      if (in_valid && in_ready) begin
        mq.push_back({2'b00, 8'(2 * (idx + 1))});
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 4) begin a = 8'(idx + 1); b = 8'(idx + 1); end
      else in_valid = 1'b0;
    end
    check("bp_total_accepts", 64'(idx), 64'(4));
    repeat (2) @(posedge clk);
    #1;
    check("bp_drained", 64'(mq.size()), 64'(0));

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h33; b = 8'h44;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_inflight_valid", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1 check("mid_reset_async_drop", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("mid_reset_no_stale", 64'(out_valid), 64'(0));
    end

    t = 0;
    while (n_done < 9 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (n_done < 9) begin
      n_vec++; n_bad++;
      $display("FAIL random_timeout: %0d of 9 configs finished", n_done);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the one-bit full adder: WIDTH-bit add/subtract with carry-in.
- The addition is split into STAGES carry-propagating slices, with one register stage per slice.
- Valid/ready handshake on input and output, with full backpressure.
- Used as the arithmetic building block under the class-based env (gen/drv/mon/scrb) with a scoreboard reference model.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥1.
- STAGES, 2, number of pipeline slices/register stages; must be ≥1 and divide WIDTH exactly, otherwise elaboration error ($fatal).
- SEG, WIDTH/STAGES (localparam), bits summed per stage.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept a transaction this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0 = add (a+b+cin), 1 = subtract (a-b-cin)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- carry  out  1  carry-out (add); for sub, 1 = no borrow
- overflow  out  1  two's-complement signed overflow

Behaviour:
- Reset (rst_n low, async): all stage valid bits 0, all data/carry/flag registers 0. Hence out_valid=0, sum=0, carry=0, overflow=0. in_ready=1 in the first cycle after release.
- Operand conditioning at capture:
  - b_eff = sub ? ~b : b
  - c0 = sub ? ~cin : cin
- Handshakes:
  - Accept on in_valid && in_ready.
  - Deliver on out_valid && out_ready.
  - Inputs are sampled only on accept. Outputs hold stable while out_valid && !out_ready.
- Stage k (0..STAGES-1):
  - Computes the slice [k*SEG +: SEG] of a + b_eff using the carry registered by stage k-1 (stage 0 uses c0).
  - Registers the partial sum so far, the slice carry, and the not-yet-summed upper operand slices (skew pipeline).
  - Stage STAGES-1 additionally registers carry = carry out of bit WIDTH-1 and overflow = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
- Latency: a result appears on out_valid exactly STAGES cycles after accept when there is no backpressure. Throughput is one transaction per cycle.
- Flow control:
  - ready_k = !valid_k || ready_(k+1), with ready_STAGES = out_ready.
  - in_ready = ready_0. Combinational ready path only; no valid-to-ready loop.
  - Capacity is STAGES transactions. With out_ready=0, exactly STAGES transactions are accepted, then in_ready=0.
- Simultaneous accept and deliver when full (out_ready=1): the pipeline shifts, a new input is accepted the same cycle, and no bubble is inserted.
- Ordering: strictly in order; no drop, no duplicate.
- Wrap-around: sum is modulo 2^WIDTH. Carry/overflow are the only indication.
- STAGES=1: single register stage, latency 1.
- Reset mid-operation: all in-flight transactions are discarded immediately (out_valid falls asynchronously). No stale result is presented after release.
- X on a/b/cin/sub while in_valid=0 must not propagate to any valid output.

Decomposition:
- Package adder_pkg:
  - typedef enum logic {OP_ADD, OP_SUB} op_e
  - function ref_add(a, b, cin, op) returning {overflow, carry, sum} for the scoreboard, parametrised via a class or WIDTH-parameterised function
- Sub-module adder_slice (parameter SEG): one combinational SEG-bit ripple slice plus its pipeline register, valid bit and ready logic. It is instantiated STAGES times in a generate loop. The top level holds operand conditioning and the final carry/overflow.

Test Plan (WIDTH=8, STAGES=2 unless noted):
- Reset: hold rst_n=0 for 3 cycles, in_valid=0 → out_valid=0, sum=8'h00, carry=0, overflow=0; in_ready=1 after release.
- Add with wrap: a=8'hFF, b=8'h01, cin=0, sub=0 → 2 cycles later sum=8'h00, carry=1, overflow=0. Then a=8'h7F, b=8'h01 → sum=8'h80, carry=0, overflow=1.
- Subtract: a=8'h05, b=8'h07, cin=0, sub=1 → sum=8'hFE, carry=0 (borrow), overflow=0. Then a=8'h80, b=8'h01, sub=1 → sum=8'h7F, carry=1, overflow=1.
- Backpressure: out_ready=0 while driving 4 back-to-back inputs (1+1, 2+2, 3+3, 4+4):
  - in_ready drops after 2 accepts.
  - Raise out_ready → outputs 8'h02, 8'h04, 8'h06, 8'h08 in order, one per cycle.
  - sum is stable while stalled.
- Reset mid-flight: 2 transactions in flight, pulse rst_n low for 1 cycle asynchronously → out_valid=0 immediately; no result appears for 5 cycles after release with in_valid=0.
- Random: 1000 vectors, random sub/cin/out_ready, WIDTH∈{8,16,32} × STAGES∈{1,2,4} → every delivered result matches ref_add, in order, count equal to accepts.
